// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter:
//   - state_t      : arbiter FSM state encoding
//   - P_CPU, P_LDR : port indices (processor = 0, loader/debug master = 1)
//   - DEF_AW, DEF_DW, DEF_DEPTH : default address width, data width and
//                    number of implemented memory words
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 3;

endpackage : mem_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0] in  : request from port 0 / port 1
//   last     in  : index of the port granted most recently
//   win      out : index of the winning port (meaningful only when any = 1)
//   any      out : at least one request is pending
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win,
    output logic       any
);

    assign any = |req;

    // On a tie the port that did not win last time goes next; otherwise the
    // single requester wins (req[1] alone selects port 1, else port 0).
    assign win = (req[0] & req[1]) ? ~last : req[1];

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing a single-port, registered-read memory between
// the processor (port 0) and a loader/debug master (port 1). Each accepted
// request becomes one ACCESS cycle carrying a read or write strobe; reads
// spend one more CAPTURE cycle and return data with a registered rvalid.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req0/1, we0/1, addr0/1, wdata0/1 : requester side, held until gnt
//   gnt0/1                         : one-cycle accept pulse (ACCESS cycle)
//   err0/1                         : out-of-range pulse, coincident with gnt
//   rvalid0/1, rdata0/1            : read return; rdata holds between pulses
//   mem_r, mem_w, mem_addr         : memory strobes and address
//   mem_wdata, mem_data_oe         : write data and bus drive enable
//   mem_rdata                      : memory read data, valid cycle after mem_r
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,

    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,

    output logic          mem_r,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_data_oe,
    input  logic [DW-1:0] mem_rdata
);

    // One extra bit so that a DEPTH equal to 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        r_state;
    logic          r_last;
    logic          r_cur;
    logic          r_we;
    logic          r_oor;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_gnt;
    logic [1:0]    r_err;
    logic [1:0]    r_rvalid;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_mem_r;
    logic          r_mem_w;

    logic          w_win;
    logic          w_any;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_in_range;
    logic [DW-1:0] w_cap_data;

    rr_arb2 u_rr_arb2 (
        .req  ({req1, req0}),
        .last (r_last),
        .win  (w_win),
        .any  (w_any)
    );

    // Winner's request fields, selected combinationally for the IDLE decision.
    assign w_we       = (w_win == P_LDR) ? we1    : we0;
    assign w_addr     = (w_win == P_LDR) ? addr1  : addr0;
    assign w_wdata    = (w_win == P_LDR) ? wdata1 : wdata0;
    assign w_in_range = {1'b0, w_addr} < DEPTH_W;

    // Out-of-range reads return zero instead of whatever the memory drives.
    assign w_cap_data = r_oor ? '0 : mem_rdata;

    // All strobe/handshake outputs are computed one edge early (on the
    // IDLE -> ACCESS transition) so that they are registered yet still land
    // exactly in the ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= P_LDR;
            r_cur    <= P_CPU;
            r_we     <= 1'b0;
            r_oor    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_gnt    <= '0;
            r_err    <= '0;
            r_rvalid <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_mem_r  <= 1'b0;
            r_mem_w  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout: every register here
            // must see the pre-edge values of its neighbours, and the pulse
            // defaults below are overridden by later assignments in the same
            // block without creating ordering races.
            r_gnt    <= '0;
            r_err    <= '0;
            r_rvalid <= '0;
            r_mem_r  <= 1'b0;
            r_mem_w  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state       <= ACCESS;
                        r_cur         <= w_win;
                        r_last        <= w_win;
                        r_we          <= w_we;
                        r_oor         <= !w_in_range;
                        r_addr        <= w_addr;
                        r_wdata       <= w_wdata;
                        r_gnt[w_win]  <= 1'b1;
                        r_err[w_win]  <= !w_in_range;
                        r_mem_r       <= w_in_range && !w_we;
                        r_mem_w       <= w_in_range && w_we;
                    end
                end

                ACCESS: begin
                    // Writes (including dropped out-of-range ones) finish here.
                    r_state <= r_we ? IDLE : CAPTURE;
                end

                CAPTURE: begin
                    r_state           <= IDLE;
                    r_rvalid[r_cur]   <= 1'b1;
                    if (r_cur == P_LDR) begin
                        r_rdata1 <= w_cap_data;
                    end else begin
                        r_rdata0 <= w_cap_data;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0        = r_gnt[P_CPU];
    assign gnt1        = r_gnt[P_LDR];
    assign err0        = r_err[P_CPU];
    assign err1        = r_err[P_LDR];
    assign rvalid0     = r_rvalid[P_CPU];
    assign rvalid1     = r_rvalid[P_LDR];
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign mem_r       = r_mem_r;
    assign mem_w       = r_mem_w;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    // The bus is driven exactly when a write strobe is issued.
    assign mem_data_oe = r_mem_w;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural memory device answers the
// strobes; a reference model (array of words + round-robin order rule) predicts
// grant order, grant spacing, error pulses and returned read data.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_r, mem_w, mem_data_oe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit            model_last;

    // Behavioural memory device
    logic [DW-1:0] dev_mem [DEPTH];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .err0       (err0),
        .err1       (err1),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_data_oe(mem_data_oe),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_w && mem_addr < DEPTH)
            dev_mem[mem_addr[1:0]] <= mem_data_oe ? mem_wdata : 8'hxx;
        if (mem_r)
            mem_rdata <= (mem_addr < DEPTH) ? dev_mem[mem_addr[1:0]] : 8'hEE;
    end

    // Runs one scenario: port p issues n<p> identical accesses, holding req
    // until the last grant. Returns the cycle of each port's first grant
    // (cycle 1 = first negedge after the requests are presented).
    task automatic run_round(input int n0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                             input int n1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                             output int g0_cyc, output int g1_cyc);
        int            rem [2];
        logic          wv [2];
        logic [7:0]    av [2];
        logic [7:0]    dv [2];
        bit            pend [2];
        int            due [2];
        logic [7:0]    exp_rd [2];
        int            last_g_cyc;
        bit            last_g_we;
        int            cyc;
        bit            done;
        rem[0] = n0; rem[1] = n1;
        wv[0] = w0;  wv[1] = w1;
        av[0] = a0;  av[1] = a1;
        dv[0] = d0;  dv[1] = d1;
        pend[0] = 0; pend[1] = 0;
        due[0] = 0;  due[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_g_cyc = -1; last_g_we = 0;
        g0_cyc = -1; g1_cyc = -1;
        req0 = (n0 > 0); we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = (n1 > 0); we1 = w1; addr1 = a1; wdata1 = d1;
        cyc = 0;
        done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (mem_r && mem_w) begin
                errors++; $display("FAIL strobe_excl cyc=%0d mem_r=%b mem_w=%b required not both", cyc, mem_r, mem_w);
            end
            checks++;
            if ((mem_r || mem_w) && !(gnt0 || gnt1)) begin
                errors++; $display("FAIL strobe_no_gnt cyc=%0d mem_r=%b mem_w=%b gnt=%b%b", cyc, mem_r, mem_w, gnt1, gnt0);
            end
            checks++;
            if (mem_data_oe !== mem_w) begin
                errors++; $display("FAIL oe cyc=%0d mem_data_oe=%b required %b", cyc, mem_data_oe, mem_w);
            end
            for (int p = 0; p < 2; p++) begin
                logic       rv;
                logic [7:0] rd;
                rv = p ? rvalid1 : rvalid0;
                rd = p ? rdata1 : rdata0;
                if (rv) begin
                    checks++;
                    if (!pend[p] || cyc != due[p]) begin
                        errors++; $display("FAIL rvalid_timing port=%0d cyc=%0d required cyc=%0d pending=%0b", p, cyc, due[p], pend[p]);
                    end else begin
                        checks++;
                        if (rd !== exp_rd[p]) begin
                            errors++; $display("FAIL rdata port=%0d got=%h required=%h", p, rd, exp_rd[p]);
                        end
                    end
                    pend[p] = 0;
                end else if (pend[p] && cyc >= due[p]) begin
                    checks++; errors++;
                    $display("FAIL rvalid_missing port=%0d cyc=%0d required at cyc=%0d", p, cyc, due[p]);
                    pend[p] = 0;
                end
            end
            if (gnt0 || gnt1) begin
                int  obs_p;
                int  exp_p;
                int  exp_gap;
                bit  inr;
                obs_p = gnt1 ? 1 : 0;
                checks++;
                if (gnt0 && gnt1) begin
                    errors++; $display("FAIL gnt_both cyc=%0d gnt0=1 gnt1=1 required one", cyc);
                end
                if (rem[0] == 0 && rem[1] == 0) begin
                    checks++; errors++;
                    $display("FAIL gnt_spurious cyc=%0d gnt=%b%b required none", cyc, gnt1, gnt0);
                end else begin
                    if (rem[0] > 0 && rem[1] > 0) exp_p = model_last ? 0 : 1;
                    else                          exp_p = (rem[0] > 0) ? 0 : 1;
                    checks++;
                    if (obs_p != exp_p) begin
                        errors++; $display("FAIL gnt_port cyc=%0d got=%0d required=%0d", cyc, obs_p, exp_p);
                    end
                    model_last = exp_p[0];
                    exp_gap = (last_g_cyc < 0) ? 1 : (last_g_we ? 2 : 3);
                    checks++;
                    if (cyc - ((last_g_cyc < 0) ? 0 : last_g_cyc) != exp_gap) begin
                        errors++; $display("FAIL gnt_spacing cyc=%0d got gap=%0d required=%0d", cyc,
                                           cyc - ((last_g_cyc < 0) ? 0 : last_g_cyc), exp_gap);
                    end
                    inr = av[exp_p] < DEPTH;
                    checks++;
                    if (err0 !== (exp_p == 0 && !inr) || err1 !== (exp_p == 1 && !inr)) begin
                        errors++; $display("FAIL err cyc=%0d err=%b%b required oor=%0b port=%0d", cyc, err1, err0, !inr, exp_p);
                    end
                    checks++;
                    if (mem_r !== (!wv[exp_p] && inr) || mem_w !== (wv[exp_p] && inr)) begin
                        errors++; $display("FAIL strobe cyc=%0d mem_r=%b mem_w=%b required r=%0b w=%0b", cyc, mem_r, mem_w,
                                           !wv[exp_p] && inr, wv[exp_p] && inr);
                    end
                    if (inr) begin
                        checks++;
                        if (mem_addr !== av[exp_p]) begin
                            errors++; $display("FAIL mem_addr cyc=%0d got=%h required=%h", cyc, mem_addr, av[exp_p]);
                        end
                    end
                    if (wv[exp_p] && inr) begin
                        checks++;
                        if (mem_wdata !== dv[exp_p]) begin
                            errors++; $display("FAIL mem_wdata cyc=%0d got=%h required=%h", cyc, mem_wdata, dv[exp_p]);
                        end
                        ref_mem[av[exp_p][1:0]] = dv[exp_p];
                    end
                    if (!wv[exp_p]) begin
                        pend[exp_p]   = 1;
                        due[exp_p]    = cyc + 2;
                        exp_rd[exp_p] = inr ? ref_mem[av[exp_p][1:0]] : 8'h00;
                    end
                    if (exp_p == 0 && g0_cyc < 0) g0_cyc = cyc;
                    if (exp_p == 1 && g1_cyc < 0) g1_cyc = cyc;
                    rem[exp_p]--;
                    if (rem[exp_p] == 0) begin
                        if (exp_p == 0) req0 = 1'b0;
                        else            req1 = 1'b0;
                    end
                    last_g_cyc = cyc;
                    last_g_we  = wv[exp_p];
                end
            end
            done = (rem[0] == 0 && rem[1] == 0 && !pend[0] && !pend[1]);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL round_timeout rem=%0d/%0d pend=%0b/%0b required all served", rem[0], rem[1], pend[0], pend[1]);
            req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
            errors++; $display("FAIL idle_quiet gnt=%b%b rvalid=%b%b required 0", gnt1, gnt0, rvalid1, rvalid0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1} !== 6'b0) begin
            errors++; $display("FAIL %s_handshake gnt=%b%b rvalid=%b%b err=%b%b required 0", tag, gnt1, gnt0, rvalid1, rvalid0, err1, err0);
        end
        checks++;
        if ({mem_r, mem_w, mem_data_oe} !== 3'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL %s_membus r=%b w=%b oe=%b addr=%h wdata=%h required 0", tag, mem_r, mem_w, mem_data_oe, mem_addr, mem_wdata);
        end
        checks++;
        if (rdata0 !== '0 || rdata1 !== '0) begin
            errors++; $display("FAIL %s_rdata rdata0=%h rdata1=%h required 0", tag, rdata0, rdata1);
        end
    endtask

    task automatic test_reset;
        int g0, g1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        model_last = 1;
        @(negedge clk);
        run_round(1, 1'b0, 8'd0, 8'h00, 0, 1'b0, 8'd0, 8'h00, g0, g1);
        checks++;
        if (g0 != 1) begin
            errors++; $display("FAIL reset_first_gnt got cyc=%0d required 1", g0);
        end
        checks++;
        if (rdata0 !== 8'h55) begin
            errors++; $display("FAIL reset_read rdata0=%h required 55", rdata0);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt0 && n < 5);
        req0 = 1'b0;
        checks++;
        if (!gnt0) begin
            errors++; $display("FAIL midrst_gnt gnt0=%b required 1", gnt0);
        end
        @(negedge clk);   // CAPTURE cycle
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid0 !== 1'b0) begin
                errors++; $display("FAIL midrst_rvalid i=%0d rvalid0=%b required 0", i, rvalid0);
            end
        end
        rst_n = 1'b1;
        model_last = 1;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
            errors++; $display("FAIL midrst_after rvalid0=%b rdata0=%h required 0/00", rvalid0, rdata0);
        end
    endtask

    task automatic test_tie;
        int g0, g1;
        run_round(1, 1'b0, 8'd0, 8'h00, 1, 1'b0, 8'd1, 8'h00, g0, g1);
        checks++;
        if (g0 != 1 || g1 - g0 != 3) begin
            errors++; $display("FAIL tie_order gnt0 cyc=%0d gnt1 cyc=%0d required 1 and 4", g0, g1);
        end
        checks++;
        if (rdata0 !== 8'h55 || rdata1 !== 8'hAA) begin
            errors++; $display("FAIL tie_data rdata0=%h rdata1=%h required 55/AA", rdata0, rdata1);
        end
    endtask

    task automatic test_write_read;
        int g0, g1;
        run_round(0, 1'b0, 8'd0, 8'h00, 1, 1'b1, 8'd2, 8'h3C, g0, g1);
        run_round(1, 1'b0, 8'd2, 8'h00, 0, 1'b0, 8'd0, 8'h00, g0, g1);
        checks++;
        if (rdata0 !== 8'h3C) begin
            errors++; $display("FAIL write_read rdata0=%h required 3C", rdata0);
        end
    endtask

    task automatic test_out_of_range;
        int g0, g1;
        run_round(1, 1'b0, 8'd5, 8'h00, 0, 1'b0, 8'd0, 8'h00, g0, g1);
        checks++;
        if (rdata0 !== 8'h00) begin
            errors++; $display("FAIL oor_read rdata0=%h required 00", rdata0);
        end
        run_round(0, 1'b0, 8'd0, 8'h00, 1, 1'b1, 8'd5, 8'h77, g0, g1);
        for (int a = 0; a < DEPTH; a++)
            run_round(1, 1'b0, 8'(a), 8'h00, 0, 1'b0, 8'd0, 8'h00, g0, g1);
    endtask

    task automatic test_back_to_back;
        int g0, g1;
        run_round(3, 1'b0, 8'd0, 8'h00, 0, 1'b0, 8'd0, 8'h00, g0, g1);
        checks++;
        if (rdata0 !== 8'h55) begin
            errors++; $display("FAIL b2b_data rdata0=%h required 55", rdata0);
        end
    endtask

    task automatic test_random;
        int g0, g1;
        for (int r = 0; r < 40; r++) begin
            int n0, n1;
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 == 0 && n1 == 0) n0 = 1;
            run_round(n0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 8'($urandom),
                      n1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 8'($urandom), g0, g1);
        end
    endtask

    initial begin
        dev_mem[0] = 8'h55; dev_mem[1] = 8'hAA; dev_mem[2] = 8'h00;
        ref_mem[0] = 8'h55; ref_mem[1] = 8'hAA; ref_mem[2] = 8'h00;
        model_last = 1;
        test_reset();
        test_mid_reset();
        test_tie();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
